// File: rtl/adder_sum_display.sv
// Captures the 5-bit adder result on a button press, converts it to BCD with a
// one-iteration-per-clock double-dabble and drives two seven-segment digits plus LEDs.
module adder_sum_display #(
  parameter int SYNC_STAGES    = 2,
  parameter bit HEX_ACTIVE_LOW = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESETN,
  input  logic [4:0] SUM,
  input  logic       LOAD_N,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [4:0] LEDR,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] HEX0_RST  = HEX_ACTIVE_LOW ? SEG_ZERO  : ~SEG_ZERO;
  localparam logic [6:0] HEX1_RST  = HEX_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  function automatic logic [6:0] seg_lo(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] polar(input logic [6:0] s);
    return HEX_ACTIVE_LOW ? s : ~s;
  endfunction

  // Button synchroniser; reset to the released level so reset exit cannot fake a press.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_load_prev;
  logic                   w_load_pulse;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_sync      <= '1;
      r_load_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes this a shift chain rather than a single wire.
      r_sync      <= {r_sync[SYNC_STAGES-2:0], LOAD_N};
      r_load_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_load_pulse = r_load_prev & ~r_sync[SYNC_STAGES-1];

  state_t     r_state, w_state_nxt;
  logic [4:0] r_bin_sh, w_bin_sh_nxt;
  logic [7:0] r_bcd, w_bcd_nxt;
  logic [2:0] r_iter, w_iter_nxt;
  logic [4:0] r_cap, w_cap_nxt;
  logic [6:0] r_hex0, w_hex0_nxt;
  logic [6:0] r_hex1, w_hex1_nxt;
  logic [4:0] r_ledr, w_ledr_nxt;
  logic       r_busy, w_busy_nxt;
  logic [7:0] w_bcd_adj;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_state  <= ST_IDLE;
      r_bin_sh <= '0;
      r_bcd    <= '0;
      r_iter   <= '0;
      r_cap    <= '0;
      r_hex0   <= HEX0_RST;
      r_hex1   <= HEX1_RST;
      r_ledr   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bin_sh <= w_bin_sh_nxt;
      r_bcd    <= w_bcd_nxt;
      r_iter   <= w_iter_nxt;
      r_cap    <= w_cap_nxt;
      r_hex0   <= w_hex0_nxt;
      r_hex1   <= w_hex1_nxt;
      r_ledr   <= w_ledr_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Add-3 correction on any BCD nibble that would overflow past 9 after the shift.
  always_comb begin
    w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_bin_sh_nxt = r_bin_sh;
    w_bcd_nxt    = r_bcd;
    w_iter_nxt   = r_iter;
    w_cap_nxt    = r_cap;
    w_hex0_nxt   = r_hex0;
    w_hex1_nxt   = r_hex1;
    w_ledr_nxt   = r_ledr;
    w_busy_nxt   = r_busy;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_pulse) begin
          w_bin_sh_nxt = SUM;
          w_cap_nxt    = SUM;
          w_bcd_nxt    = 8'h00;
          w_iter_nxt   = 3'd0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        w_bcd_nxt    = {w_bcd_adj[6:0], r_bin_sh[4]};
        w_bin_sh_nxt = {r_bin_sh[3:0], 1'b0};
        w_iter_nxt   = r_iter + 3'd1;
        if (r_iter == 3'd4) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_ledr_nxt  = r_cap;
        w_hex0_nxt  = polar(seg_lo(r_bcd[3:0]));
        w_hex1_nxt  = (r_bcd[7:4] == 4'd0) ? polar(SEG_BLANK) : polar(seg_lo(r_bcd[7:4]));
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign HEX0 = r_hex0;
  assign HEX1 = r_hex1;
  assign LEDR = r_ledr;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_adder_sum_display.sv
// Directed and randomized bench for adder_sum_display; expected digits come from
// plain decimal arithmetic on the loaded value and the board segment table.
module tb_adder_sum_display;

  logic       clk = 1'b0;
  logic       RESETN;
  logic [4:0] SUM;
  logic       LOAD_N;
  logic [6:0] HEX0, HEX1;
  logic [4:0] LEDR;
  logic       BUSY;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  adder_sum_display dut (
    .CLOCK_50 (clk),
    .RESETN   (RESETN),
    .SUM      (SUM),
    .LOAD_N   (LOAD_N),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .LEDR     (LEDR),
    .BUSY     (BUSY)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_hex0(input int v);
    return seg_tab[v % 10];
  endfunction

  function automatic logic [6:0] exp_hex1(input int v);
    return (v < 10) ? BLANK : seg_tab[v / 10];
  endfunction

  // Press for 'hold' cycles, scramble SUM after capture, observe BUSY over a fixed window.
  task automatic run_load(input logic [4:0] s, input int hold, output int rises, output int busy_cyc);
    logic prev;
    rises    = 0;
    busy_cyc = 0;
    @(negedge clk);
    prev   = BUSY;
    SUM    = s;
    LOAD_N = 1'b0;
    for (int c = 1; c <= hold + 20; c++) begin
      @(negedge clk);
      if (c == hold) LOAD_N = 1'b1;
      if (c == 5) SUM = 5'($urandom);
      if (BUSY && !prev) rises++;
      if (BUSY) busy_cyc++;
      prev = BUSY;
    end
  endtask

  task automatic check_display(input string tag, input int v);
    check({tag, "_hex0"}, 32'(HEX0), 32'(exp_hex0(v)));
    check({tag, "_hex1"}, 32'(HEX1), 32'(exp_hex1(v)));
    check({tag, "_ledr"}, 32'(LEDR), 32'(v));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hex0"}, 32'(HEX0), 32'(7'b1000000));
    check({tag, "_hex1"}, 32'(HEX1), 32'(BLANK));
    check({tag, "_ledr"}, 32'(LEDR), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int rises, busy_cyc, v, hold, seen;
    logic prev;

    // Reset held with activity on the inputs.
    RESETN = 1'b0;
    SUM    = 5'd17;
    LOAD_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      LOAD_N = ~LOAD_N;
    end
    @(negedge clk);
    check_reset_vals("reset_hold");
    LOAD_N = 1'b1;
    @(negedge clk);
    RESETN = 1'b1;
    rises  = 0;
    prev   = BUSY;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (BUSY && !prev) rises++;
      prev = BUSY;
    end
    check("reset_release_no_load", 32'(rises), 32'd0);
    check_reset_vals("reset_release");

    // Basic load.
    run_load(5'd9, 10, rises, busy_cyc);
    check("basic_rises", 32'(rises), 32'd1);
    check("basic_busy_len", 32'(busy_cyc), 32'd6);
    check("basic_hex0", 32'(HEX0), 32'(7'b0010000));
    check("basic_hex1", 32'(HEX1), 32'(BLANK));
    check("basic_ledr", 32'(LEDR), 32'(5'b01001));

    // Maximum value.
    run_load(5'd31, 10, rises, busy_cyc);
    check("max_hex1", 32'(HEX1), 32'(7'b0110000));
    check("max_hex0", 32'(HEX0), 32'(7'b1111001));
    check("max_ledr", 32'(LEDR), 32'(5'b11111));

    // Exhaustive sweep with a long hold: exactly one conversion per press.
    for (int s = 0; s < 32; s++) begin
      run_load(5'(s), 20, rises, busy_cyc);
      check($sformatf("sweep%0d_rises", s), 32'(rises), 32'd1);
      check($sformatf("sweep%0d_busy", s), 32'(busy_cyc), 32'd6);
      check_display($sformatf("sweep%0d", s), s);
    end

    // Random values and random press lengths.
    for (int k = 0; k < 12; k++) begin
      v    = int'($urandom_range(0, 31));
      hold = int'($urandom_range(1, 20));
      run_load(5'(v), hold, rises, busy_cyc);
      check($sformatf("rand%0d_rises", k), 32'(rises), 32'd1);
      check($sformatf("rand%0d_busy", k), 32'(busy_cyc), 32'd6);
      check_display($sformatf("rand%0d_v%0d", k, v), v);
    end

    // Second press while busy is ignored.
    @(negedge clk);
    SUM    = 5'd22;
    LOAD_N = 1'b0;
    seen   = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (BUSY) seen = 1;
    end
    check("collide_busy_rise", 32'(seen), 32'd1);
    LOAD_N = 1'b1;
    repeat (2) @(negedge clk);
    SUM    = 5'd5;
    LOAD_N = 1'b0;
    rises  = 0;
    prev   = BUSY;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 5) LOAD_N = 1'b1;
      if (BUSY && !prev) rises++;
      prev = BUSY;
    end
    check("collide_no_second", 32'(rises), 32'd0);
    check_display("collide", 22);

    // Reset asserted in the middle of a conversion.
    @(negedge clk);
    SUM    = 5'd18;
    LOAD_N = 1'b0;
    seen   = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (BUSY) seen = 1;
    end
    check("midrst_busy_rise", 32'(seen), 32'd1);
    LOAD_N = 1'b1;
    repeat (2) @(negedge clk);
    #3 RESETN = 1'b0;
    #1;
    check_reset_vals("midrst_async");
    repeat (2) @(negedge clk);
    RESETN = 1'b1;
    rises  = 0;
    prev   = BUSY;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (BUSY && !prev) rises++;
      prev = BUSY;
    end
    check("midrst_no_restart", 32'(rises), 32'd0);
    check_reset_vals("midrst_after");

    // A fresh press after the abort works normally.
    run_load(5'd18, 4, rises, busy_cyc);
    check("post_rst_rises", 32'(rises), 32'd1);
    check_display("post_rst", 18);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_sum_display.md
Name: adder_sum_display

Overview:
- Downstream consumer of the 4-bit ripple adder's 5-bit result {carry, sum[3:0]}, range 0..31.
- On a pushbutton press, captures the sum and converts it to two BCD digits with a sequential double-dabble, one iteration per clock.
- Drives two seven-segment digits and a latched binary copy on the red LEDs.
- Sits between the adder and the board display pins.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on LOAD_N; legal values 2..3.
- HEX_ACTIVE_LOW, 1, 1 = segment on when bit is 0 (board default); 0 = all segment outputs inverted.

Ports:
- CLOCK_50  in   1  system clock, 50 MHz.
- RESETN    in   1  asynchronous, active-low reset.
- SUM       in   5  adder result; SUM[4] = carry-out, SUM[3:0] = sum bits. Quasi-static, unsynchronised.
- LOAD_N    in   1  pushbutton, active-low, asynchronous to CLOCK_50.
- HEX0      out  7  ones digit segments, bit0 = a … bit6 = g.
- HEX1      out  7  tens digit segments, same bit order.
- LEDR      out  5  binary value last displayed.
- BUSY      out  1  high while a conversion is in progress.

Behaviour:
- Reset (async assert, RESETN=0):
  - state=IDLE, BUSY=0, LEDR=0.
  - HEX0 = digit '0' (7'b1000000 active-low); HEX1 = blank (7'b1111111 active-low).
  - Synchroniser flops and the edge register reset to 1 (button released), so reset release creates no load pulse.
  - Reset asserted mid-conversion aborts immediately; displays return to reset values.
- Input sync:
  - LOAD_N passes through SYNC_STAGES flops.
  - load_pulse = 1 for exactly one cycle when the previous synchronised value is 1 and the current one is 0 (falling edge).
  - Holding the button produces no further pulses.
- FSM, states IDLE, CONVERT, DONE:
  - IDLE: on load_pulse, bin_sh <= SUM, bcd <= 8'h00, iter <= 0, BUSY <= 1, go to CONVERT. Otherwise hold.
  - CONVERT, one cycle per iteration:
    - First, for each bcd nibble ≥5, add 3 to that nibble.
    - Then shift {bcd, bin_sh} left by 1.
    - iter increments; after the 5th iteration (iter==4 at the edge) go to DONE.
  - DONE, one cycle:
    - LEDR <= captured SUM value; HEX0 <= seg(bcd[3:0]).
    - HEX1 <= blank if bcd[7:4]==0, else seg(bcd[7:4]).
    - BUSY <= 0; go to IDLE.
- Latency:
  - Let edge E be the one where IDLE accepts load_pulse; BUSY rises at E.
  - CONVERT occupies the 5 cycles after E; DONE is the 6th.
  - Outputs update and BUSY falls at edge E+6. Total 6 cycles from capture.
- Loads during CONVERT/DONE are ignored, not queued. SUM changes after capture have no effect on the conversion in progress.
- Width rules: bin_sh 5 bits, bcd 8 bits. Tens digit max 3, so HEX1 only ever shows blank, 1, 2 or 3.
- Segment encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - When HEX_ACTIVE_LOW=0, every bit of HEX0/HEX1 is inverted, including the blank value.
- HEX0, HEX1, LEDR and BUSY are all registered outputs; no combinational path from SUM or LOAD_N to any output.

Test Plan:
- Reset check: hold RESETN=0 with SUM=5'd17 and LOAD_N toggling -> HEX0=1000000, HEX1=1111111, LEDR=0, BUSY=0. Release reset with LOAD_N=1 -> no conversion starts.
- Basic load: SUM=5'd9, pulse LOAD_N low for 10 cycles -> BUSY high for exactly 6 cycles; then HEX0=0010000 ('9'), HEX1=1111111 (blank), LEDR=01001.
- Maximum value: SUM=5'd31 (15+15+cin) and load -> HEX1=0110000 ('3'), HEX0=1111001 ('1'), LEDR=11111.
- Exhaustive sweep: loop SUM over 0..31, one load each -> HEX digits match floor(SUM/10) and SUM%10. Tens digit blank for SUM<10 and shows '1'/'2'/'3' otherwise. Exactly one conversion per press, with LOAD_N held low for 20 cycles.
- Busy collision: load SUM=5'd22; 2 cycles after BUSY rises, change SUM to 5'd5 and press again -> display shows '22' and LEDR=10110. Second press is ignored with no later conversion.
- Reset mid-operation: load SUM=5'd18, assert RESETN at CONVERT cycle 3 -> BUSY=0 and reset display values asynchronously. After release, no output change until a new press.
